// File: rtl/w_pattern_tx.sv
// w_pattern_tx: serial pattern transmitter for the run-of-ones detector.
// Takes a parallel word over a ready/load handshake, shifts it out LSB-first
// on w, then drives a forced-zero gap. Also models the detector's z output
// (exp_z) and keeps a saturating count of exp_z rising edges.
module w_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2,
  parameter int CW    = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             clr_count,
  output logic             ready,
  output logic             busy,
  output logic             w,
  output logic             done,
  output logic             exp_z,
  output logic [CW-1:0]    det_count
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [GW-1:0]    gapcnt_q, gapcnt_d;
  logic             w_q, w_d;
  logic             done_q, done_d;
  logic             p1_q, p1_d;
  logic             p2_q, p2_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rise_s;

  // Transmit FSM: next state, shifter, counters, and the registered w/done values.
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    w_d      = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          w_d      = data_in[0];
          sh_d     = data_in >> 1'b1;
          bitcnt_d = BIT_LAST;
          state_d  = S_SHIFT;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (bitcnt_q != '0) begin
          w_d      = sh_q[0];
          sh_d     = sh_q >> 1'b1;
          bitcnt_d = bitcnt_q - 1'b1;
        end else if (GAP > 0) begin
          gapcnt_d = GAP_LAST;
          state_d  = S_GAP;
        end else begin
          // No gap: the IDLE cycle itself separates consecutive words.
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_GAP: begin
        if (gapcnt_q == '0) begin
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          gapcnt_d = gapcnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Detector model and saturating rising-edge counter; clear beats increment.
  always_comb begin
    p1_d   = w_q;
    p2_d   = p1_q;
    rise_s = w_q & p1_q & ~(p1_q & p2_q);
    if (clr_count) begin
      cnt_d = '0;
    end else if (rise_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and datapath registers; async reset abandons any word in flight.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= S_IDLE;
      sh_q     <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
      w_q      <= 1'b0;
      done_q   <= 1'b0;
      p1_q     <= 1'b0;
      p2_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
      w_q      <= w_d;
      done_q   <= done_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign busy      = ~ready;
  assign w         = w_q;
  assign done      = done_q;
  assign exp_z     = p1_q & p2_q;
  assign det_count = cnt_q;

endmodule

// File: tb/tb_w_pattern_tx.sv
// Directed testbench for w_pattern_tx: three instances cover the default
// configuration, a zero-gap configuration and a 2-bit saturating counter.
module tb_w_pattern_tx;

  logic Clock = 1'b0;
  logic Resetn;

  // Instance A: WIDTH=8, GAP=2, CW=8
  logic [7:0] data_a;
  logic       load_a, clr_a;
  logic       ready_a, busy_a, w_a, done_a, z_a;
  logic [7:0] cnt_a;

  // Instance B: WIDTH=8, GAP=0, CW=8
  logic [7:0] data_b;
  logic       load_b, clr_b;
  logic       ready_b, busy_b, w_b, done_b, z_b;
  logic [7:0] cnt_b;

  // Instance C: WIDTH=8, GAP=2, CW=2
  logic [7:0] data_c;
  logic       load_c, clr_c;
  logic       ready_c, busy_c, w_c, done_c, z_c;
  logic [1:0] cnt_c;

  int vectors    = 0;
  int miscompares = 0;

  always #5 Clock = ~Clock;

  w_pattern_tx #(.WIDTH(8), .GAP(2), .CW(8)) dut_a (
    .Clock(Clock), .Resetn(Resetn), .data_in(data_a), .load(load_a), .clr_count(clr_a),
    .ready(ready_a), .busy(busy_a), .w(w_a), .done(done_a), .exp_z(z_a), .det_count(cnt_a)
  );

  w_pattern_tx #(.WIDTH(8), .GAP(0), .CW(8)) dut_b (
    .Clock(Clock), .Resetn(Resetn), .data_in(data_b), .load(load_b), .clr_count(clr_b),
    .ready(ready_b), .busy(busy_b), .w(w_b), .done(done_b), .exp_z(z_b), .det_count(cnt_b)
  );

  w_pattern_tx #(.WIDTH(8), .GAP(2), .CW(2)) dut_c (
    .Clock(Clock), .Resetn(Resetn), .data_in(data_c), .load(load_c), .clr_count(clr_c),
    .ready(ready_c), .busy(busy_c), .w(w_c), .done(done_c), .exp_z(z_c), .det_count(cnt_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Send one word on instance A (must be idle). Checks cycles 0..10 against
  // the hand-computed exp_z mask and count step. With hold set, load stays
  // high and data_in switches to 8'hFF while busy.
  task automatic run_a(input string nm, input logic [7:0] data, input logic [10:0] zmask,
                       input logic [7:0] cnt0, input logic [7:0] cnt1, input int inc_k,
                       input bit hold);
    logic [7:0] wexp;
    data_a = data;
    load_a = 1'b1;
    tick();
    if (hold) data_a = 8'hFF;
    else      load_a = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      wexp = data;
      chk($sformatf("%s w c%0d", nm, k), w_a, (k < 8) ? wexp[k] : 1'b0);
      chk($sformatf("%s z c%0d", nm, k), z_a, zmask[k]);
      chk($sformatf("%s done c%0d", nm, k), done_a, (k == 10) ? 1'b1 : 1'b0);
      chk($sformatf("%s ready c%0d", nm, k), ready_a, (k == 10) ? 1'b1 : 1'b0);
      chk($sformatf("%s cnt c%0d", nm, k), cnt_a, (inc_k >= 0 && k >= inc_k) ? cnt1 : cnt0);
      if (k < 10) tick();
    end
    load_a = 1'b0;
  endtask

  // Send one word on instance C and stop in cycle 10 (done/ready).
  task automatic send_c(input logic [7:0] data);
    data_c = data;
    load_c = 1'b1;
    tick();
    load_c = 1'b0;
    for (int k = 0; k < 10; k++) tick();
  endtask

  initial begin
    Resetn = 1'b0;
    data_a = 8'h00; load_a = 1'b0; clr_a = 1'b0;
    data_b = 8'h00; load_b = 1'b0; clr_b = 1'b0;
    data_c = 8'h00; load_c = 1'b0; clr_c = 1'b0;

    // Reset state
    #3;
    chk("rst w", w_a, 1'b0);
    chk("rst ready", ready_a, 1'b1);
    chk("rst busy", busy_a, 1'b0);
    chk("rst done", done_a, 1'b0);
    chk("rst exp_z", z_a, 1'b0);
    chk("rst cnt", cnt_a, 8'd0);
    tick();
    Resetn = 1'b1;
    tick();
    tick();

    // 8'h06: w=0,1,1,0..., exp_z only in cycle 3, count 0->1 at cycle 3
    run_a("w06", 8'h06, 11'h008, 8'd0, 8'd1, 3, 1'b0);
    // 8'hFF: exp_z in cycles 2..8, count 1->2 at cycle 2
    run_a("wFF", 8'hFF, 11'h1FC, 8'd1, 8'd2, 2, 1'b0);
    // 8'h05 with load held while busy and data_in switched to FF
    run_a("w05", 8'h05, 11'h000, 8'd2, 8'd2, -1, 1'b1);
    tick();
    chk("w05 held load ignored ready", ready_a, 1'b1);
    chk("w05 held load ignored w", w_a, 1'b0);
    chk("w05 held load ignored busy", busy_a, 1'b0);

    // Reset pulse in cycle 4 of 8'hFF
    data_a = 8'hFF;
    load_a = 1'b1;
    tick();
    load_a = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("midrst pre w", w_a, 1'b1);
    chk("midrst pre exp_z", z_a, 1'b1);
    chk("midrst pre busy", busy_a, 1'b1);
    Resetn = 1'b0;
    #1;
    chk("midrst w", w_a, 1'b0);
    chk("midrst ready", ready_a, 1'b1);
    chk("midrst busy", busy_a, 1'b0);
    chk("midrst done", done_a, 1'b0);
    chk("midrst exp_z", z_a, 1'b0);
    chk("midrst cnt", cnt_a, 8'd0);
    #1;
    Resetn = 1'b1;
    tick();
    run_a("post06", 8'h06, 11'h008, 8'd0, 8'd1, 3, 1'b0);

    // GAP=0: 8'h80 then 8'h01 back-to-back
    data_b = 8'h80;
    load_b = 1'b1;
    tick();
    load_b = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      chk($sformatf("g0 w c%0d", k), w_b, (k == 7) ? 1'b1 : 1'b0);
      chk($sformatf("g0 z c%0d", k), z_b, 1'b0);
      chk($sformatf("g0 ready c%0d", k), ready_b, (k == 8) ? 1'b1 : 1'b0);
      chk($sformatf("g0 done c%0d", k), done_b, (k == 8) ? 1'b1 : 1'b0);
      if (k < 8) tick();
    end
    data_b = 8'h01;
    load_b = 1'b1;
    tick();
    load_b = 1'b0;
    chk("g0 second accept w", w_b, 1'b1);
    chk("g0 second accept busy", busy_b, 1'b1);
    chk("g0 second accept done", done_b, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("g0 second w c%0d", k), w_b, 1'b0);
      chk($sformatf("g0 second z c%0d", k), z_b, 1'b0);
    end
    chk("g0 cnt", cnt_b, 8'd0);

    // CW=2 saturation: 8'h03 four times -> 1,2,3,3
    send_c(8'h03);
    chk("sat cnt 1", cnt_c, 2'd1);
    send_c(8'h03);
    chk("sat cnt 2", cnt_c, 2'd2);
    send_c(8'h03);
    chk("sat cnt 3", cnt_c, 2'd3);
    send_c(8'h03);
    chk("sat cnt 3 held", cnt_c, 2'd3);
    // clr_count during the edge that would increment (edge 2)
    data_c = 8'h03;
    load_c = 1'b1;
    tick();
    load_c = 1'b0;
    tick();
    clr_c = 1'b1;
    tick();
    clr_c = 1'b0;
    chk("clr z c2", z_c, 1'b1);
    chk("clr cnt c2", cnt_c, 2'd0);
    tick();
    chk("clr cnt c3", cnt_c, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
